dsp_add_arbiter: RTL

Shares a single `dsp_add` instance, the 32-bit SB_MAC16 adder, between two requesters in the sail core. Each requester uses a valid/ready request and response handshake. The block does round-robin arbitration, registers operands in front of the DSP adder, and captures sums into per-requester result registers. It delivers one addition per cycle at a fixed two-cycle latency, so no second DSP tile is needed for address/ALU adds.

---
 rtl/dsp_add_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dsp_add_arbiter.sv
// dsp_add_arbiter
//
// Shares one 32-bit dsp_add adder between two requesters. Each requester
// issues operations over a valid/ready request channel and receives sums over
// a valid/ready response channel. Operations are picked round-robin, held in a
// single operand register stage in front of the adder, and the sums are
// captured into a result register per requester. Latency is two cycles from
// request transfer to response valid, and throughput is one add per cycle.
//
// Ports:
//   clk                     system clock, rising edge
//   rst_n                   synchronous active-low reset
//   req{0,1}_valid/_ready   request handshake per requester
//   req{0,1}_a/_b           32-bit operands per requester
//   rsp{0,1}_valid/_ready   response handshake per requester
//   rsp{0,1}_sum            32-bit result per requester
//   grant_id                requester owning the operand stage (valid when busy)
//   busy                    operand stage occupied
//   op_count                completed operations, wraps modulo 2^CNT_W

// Adder mapped onto the SB_MAC16 tile; purely combinational.
module dsp_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

module dsp_add_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_sum,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_sum,
    output logic             grant_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    logic        opnd_valid;
    logic        opnd_id;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic        prio;
    logic [31:0] dsp_sum;
    logic        adv;
    logic        load_ok;
    logic        xfer0;
    logic        xfer1;

    dsp_add u_dsp_add (
        .a   (opnd_a),
        .b   (opnd_b),
        .sum (dsp_sum)
    );

    // The operand stage drains when the result register of its owner is
    // empty or being consumed this cycle; a stalled owner blocks everybody.
    assign adv     = opnd_valid & (opnd_id ? (!rsp1_valid | rsp1_ready)
                                           : (!rsp0_valid | rsp0_ready));
    assign load_ok = !opnd_valid | adv;

    // A requester wins when it is preferred, or when the other one is idle.
    // Written this way so ready never looks at the requester's own valid.
    assign req0_ready = load_ok & (!prio | !req1_valid);
    assign req1_ready = load_ok & ( prio | !req0_valid);

    // At most one of these can be set: with both valid only the preferred
    // requester sees ready.
    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;

    assign busy     = opnd_valid;
    assign grant_id = opnd_id;

    // Operand stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opnd_valid <= 1'b0;
            opnd_id    <= 1'b0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            prio       <= 1'b0;
        end else if (load_ok) begin
            opnd_valid <= xfer0 | xfer1;
            if (xfer0) begin
                opnd_id <= 1'b0;
                opnd_a  <= req0_a;
                opnd_b  <= req0_b;
                prio    <= 1'b1;
            end else if (xfer1) begin
                opnd_id <= 1'b1;
                opnd_a  <= req1_a;
                opnd_b  <= req1_b;
                prio    <= 1'b0;
            end
        end
    end

    // Result registers; a new capture wins over a same-cycle consume so the
    // valid flag stays up while the sum is replaced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_sum   <= '0;
            rsp1_valid <= 1'b0;
            rsp1_sum   <= '0;
        end else begin
            if (adv && !opnd_id) begin
                rsp0_valid <= 1'b1;
                rsp0_sum   <= dsp_sum;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (adv && opnd_id) begin
                rsp1_valid <= 1'b1;
                rsp1_sum   <= dsp_sum;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

    // Completed-operation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (adv) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
